// File: rtl/pcie_rd_slot_sched.sv
// Slot scheduler sharing the DMA CPU-read port between two video FIFO read sides.
// Optional beat-0 owner tag on cpu_rd_data[127:112] when PCIE_SCHED_TAG_EN is defined.
module pcie_rd_slot_sched #(
  parameter int unsigned  BURST_BEATS = 161,
  parameter int unsigned  THRESH      = 160,
  parameter int unsigned  LEVEL_W     = 10,
  parameter logic [127:0] FILL_WORD   = {8{16'hFFFF}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_rd_en,
  output logic [127:0]       cpu_rd_data,
  input  logic [LEVEL_W-1:0] ch0_level,
  input  logic               ch0_flush,
  output logic               ch0_rd_en,
  input  logic [127:0]       ch0_rd_data,
  input  logic [LEVEL_W-1:0] ch1_level,
  input  logic               ch1_flush,
  output logic               ch1_rd_en,
  input  logic [127:0]       ch1_rd_data,
  output logic [1:0]         slot_owner,
  output logic [15:0]        fill_slots
);

  localparam int unsigned      CntW    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(BURST_BEATS - 1);
  localparam logic [LEVEL_W-1:0] ThreshL = LEVEL_W'(THRESH);

  typedef enum logic [1:0] {
    OwnFill = 2'd0,
    OwnCh0  = 2'd1,
    OwnCh1  = 2'd2
  } owner_e;

  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  owner_e          owner_q, owner_d, sel_q, sel_d;
  owner_e          grant, beat_owner;
  logic            last_grant_q, last_grant_d;  // 1 = ch1 was granted last
  logic [15:0]     fill_slots_q, fill_slots_d;
  logic            elig0, elig1, decide, last_beat;

  always_comb begin
    elig0 = (ch0_level >= ThreshL) && !ch0_flush;
    elig1 = (ch1_level >= ThreshL) && !ch1_flush;
    if (elig0 && elig1) grant = last_grant_q ? OwnCh0 : OwnCh1;
    else if (elig0)     grant = OwnCh0;
    else if (elig1)     grant = OwnCh1;
    else                grant = OwnFill;

    decide    = cpu_rd_en && (slot_cnt_q == '0);
    last_beat = (slot_cnt_q == LastCnt);

    beat_owner = decide ? grant : owner_q;
    // A flushed owner loses the remainder of its slot; the count still runs to the end.
    if ((beat_owner == OwnCh0 && ch0_flush) || (beat_owner == OwnCh1 && ch1_flush)) begin
      beat_owner = OwnFill;
    end
    if (rst) beat_owner = OwnFill;

    ch0_rd_en = cpu_rd_en && (beat_owner == OwnCh0);
    ch1_rd_en = cpu_rd_en && (beat_owner == OwnCh1);

    slot_cnt_d   = slot_cnt_q;
    owner_d      = beat_owner;
    last_grant_d = last_grant_q;
    fill_slots_d = fill_slots_q;
    sel_d        = cpu_rd_en ? beat_owner : OwnFill;

    if (cpu_rd_en) begin
      slot_cnt_d = last_beat ? '0 : slot_cnt_q + 1'b1;
      if (last_beat) owner_d = OwnFill;
    end
    if (decide) begin
      if (grant == OwnFill) begin
        if (fill_slots_q != 16'hFFFF) fill_slots_d = fill_slots_q + 16'd1;
      end else begin
        last_grant_d = (grant == OwnCh1);
      end
    end
  end

`ifdef PCIE_SCHED_TAG_EN
  logic tag_q, tag_d;
  assign tag_d = decide && (beat_owner != OwnFill);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      owner_q      <= OwnFill;
      sel_q        <= OwnFill;
      last_grant_q <= 1'b1;
      fill_slots_q <= 16'd0;
`ifdef PCIE_SCHED_TAG_EN
      tag_q        <= 1'b0;
`endif
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      owner_q      <= owner_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      fill_slots_q <= fill_slots_d;
`ifdef PCIE_SCHED_TAG_EN
      tag_q        <= tag_d;
`endif
    end
  end

  always_comb begin
    unique case (sel_q)
      OwnCh0:  cpu_rd_data = ch0_rd_data;
      OwnCh1:  cpu_rd_data = ch1_rd_data;
      default: cpu_rd_data = FILL_WORD;
    endcase
`ifdef PCIE_SCHED_TAG_EN
    if (tag_q) cpu_rd_data[127:112] = {8'hA5, 7'd0, (sel_q == OwnCh1)};
`endif
  end

  assign slot_owner = owner_q;
  assign fill_slots = fill_slots_q;

endmodule

// File: tb/tb_pcie_rd_slot_sched.sv
// Directed bench for pcie_rd_slot_sched with simple counting FIFO models on both channels.
module tb_pcie_rd_slot_sched;

  localparam logic [127:0] Fill = {8{16'hFFFF}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_rd_en = 1'b0;
  logic [127:0] cpu_rd_data;
  logic [9:0]   ch0_level = '0, ch1_level = '0;
  logic         ch0_flush = 1'b0, ch1_flush = 1'b0;
  logic         ch0_rd_en, ch1_rd_en;
  logic [127:0] ch0_rd_data = '0, ch1_rd_data = '0;
  logic [1:0]   slot_owner;
  logic [15:0]  fill_slots;

  int n_cmp = 0, n_bad = 0;
  int fifo_idx0 = 0, fifo_idx1 = 0;
  int exp_idx0 = 0, exp_idx1 = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0;
  logic         pend_valid = 1'b0;
  logic [127:0] pend_word = '0;

  pcie_rd_slot_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_data (cpu_rd_data),
    .ch0_level   (ch0_level),
    .ch0_flush   (ch0_flush),
    .ch0_rd_en   (ch0_rd_en),
    .ch0_rd_data (ch0_rd_data),
    .ch1_level   (ch1_level),
    .ch1_flush   (ch1_flush),
    .ch1_rd_en   (ch1_rd_en),
    .ch1_rd_data (ch1_rd_data),
    .slot_owner  (slot_owner),
    .fill_slots  (fill_slots)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkword(input int ch, input int idx);
    logic [15:0] i16;
    i16 = idx[15:0];
    return {(ch == 0) ? 4'h1 : 4'h2, i16[11:0], {7{i16}}};
  endfunction

  // FIFO models: each read pops the next numbered word, visible the following cycle.
  always @(posedge clk) begin
    if (ch0_rd_en) begin
      ch0_rd_data <= mkword(0, fifo_idx0);
      fifo_idx0   <= fifo_idx0 + 1;
    end
    if (ch1_rd_en) begin
      ch1_rd_data <= mkword(1, fifo_idx1);
      fifo_idx1   <= fifo_idx1 + 1;
    end
  end

  // One cycle, entered and left at a negedge. exp_own: 0 fill, 1 ch0, 2 ch1.
  task automatic step(input logic en, input logic [1:0] exp_own, input logic beat0);
    logic [127:0] word;
    if (pend_valid) begin
      n_cmp++;
      if (cpu_rd_data !== pend_word) begin
        n_bad++;
        $display("FAIL rd_data: got %h want %h", cpu_rd_data, pend_word);
      end
    end
    cpu_rd_en = en;
    #1;
    n_cmp++;
    if (ch0_rd_en !== (en && exp_own == 2'd1) || ch1_rd_en !== (en && exp_own == 2'd2)) begin
      n_bad++;
      $display("FAIL rd_en: got ch0=%b ch1=%b want owner %0d en %b",
               ch0_rd_en, ch1_rd_en, exp_own, en);
    end
    if (ch0_rd_en === 1'b1) rd_cnt0++;
    if (ch1_rd_en === 1'b1) rd_cnt1++;
    word = Fill;
    if (en && exp_own == 2'd1) begin
      word = mkword(0, exp_idx0);
      exp_idx0++;
    end else if (en && exp_own == 2'd2) begin
      word = mkword(1, exp_idx1);
      exp_idx1++;
    end
`ifdef PCIE_SCHED_TAG_EN
    if (beat0 && en && exp_own != 2'd0) word[127:112] = {8'hA5, 7'd0, (exp_own == 2'd2)};
`endif
    pend_valid = en;
    pend_word  = word;
    @(negedge clk);
  endtask

  task automatic slot(input logic [1:0] exp_own);
    for (int b = 0; b < 161; b++) step(1'b1, exp_own, b == 0);
  endtask

  task automatic chk2(input string name, input logic [1:0] got, input logic [1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk16(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    step(1'b0, 2'd0, 1'b0);
    n_cmp++;
    if (cpu_rd_data !== Fill) begin
      n_bad++;
      $display("FAIL reset_data: got %h want %h", cpu_rd_data, Fill);
    end
    chk16("reset_fill_slots", int'(fill_slots), 0);
    chk2("reset_owner", slot_owner, 2'd0);
  endtask

  task automatic test_single_ch0();
    int c0;
    test_reset();
    ch0_level = 10'd200;
    ch1_level = 10'd0;
    c0 = rd_cnt0;
    step(1'b1, 2'd1, 1'b1);
    chk2("ch0_owner", slot_owner, 2'd1);
    for (int b = 1; b < 161; b++) step(1'b1, 2'd1, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    chk16("ch0_reads", rd_cnt0 - c0, 161);
    chk2("ch0_owner_end", slot_owner, 2'd0);
  endtask

  task automatic test_alternate();
    int c0, c1;
    test_reset();
    ch0_level = 10'd300;
    ch1_level = 10'd300;
    c0 = rd_cnt0;
    c1 = rd_cnt1;
    slot(2'd1);
    slot(2'd2);
    slot(2'd1);
    step(1'b0, 2'd0, 1'b0);
    chk16("alt_total", (rd_cnt0 - c0) + (rd_cnt1 - c1), 483);
    chk16("alt_ch1", rd_cnt1 - c1, 161);
    chk16("alt_fill_slots", int'(fill_slots), 0);
  endtask

  task automatic test_below_thresh();
    test_reset();
    ch0_level = 10'd159;
    ch1_level = 10'd159;
    for (int b = 0; b < 161; b++) begin
      if (b == 5) ch1_level = 10'd160;
      step(1'b1, 2'd0, b == 0);
    end
    chk16("thr_fill_slots", int'(fill_slots), 1);
    for (int b = 0; b < 4; b++) step(1'b1, 2'd2, b == 0);
    chk2("thr_next_owner", slot_owner, 2'd2);
    step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_flush();
    test_reset();
    ch0_level = 10'd0;
    ch1_level = 10'd300;
    for (int b = 0; b < 40; b++) step(1'b1, 2'd2, b == 0);
    ch1_flush = 1'b1;
    step(1'b1, 2'd0, 1'b0);
    ch1_flush = 1'b0;
    chk2("flush_owner", slot_owner, 2'd0);
    for (int b = 41; b < 161; b++) step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b1);
    chk2("flush_rearb", slot_owner, 2'd2);
    chk16("flush_fill_slots", int'(fill_slots), 0);
    step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_gapped();
    int c1;
    test_reset();
    ch0_level = 10'd0;
    ch1_level = 10'd200;
    c1 = rd_cnt1;
    for (int b = 0; b < 161; b++) begin
      step(1'b1, 2'd2, b == 0);
      step(1'b0, 2'd2, 1'b0);
      step(1'b0, 2'd2, 1'b0);
    end
    chk16("gap_reads", rd_cnt1 - c1, 161);
    chk2("gap_owner_end", slot_owner, 2'd0);
    step(1'b1, 2'd2, 1'b1);
    step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    test_reset();
    ch0_level = 10'd200;
    ch1_level = 10'd200;
    for (int b = 0; b < 50; b++) step(1'b1, 2'd1, b == 0);
    rst = 1'b1;
    step(1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    chk2("rstmid_owner", slot_owner, 2'd0);
    step(1'b1, 2'd1, 1'b1);
    chk2("rstmid_regrant", slot_owner, 2'd1);
    step(1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_ch0();
    test_alternate();
    test_below_thresh();
    test_flush();
    test_gapped();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
